// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: the transaction FSM encoding and the
// byte-enable patterns driven onto the data-memory port.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte out of a memory word and sign- or zero-extends it;
// word loads pass the memory data through unchanged.
module load_extend #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_byte,
  input  logic                  i_hiByte,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0] w_byte;
  logic       w_sign;

  always_comb begin
    w_byte = i_hiByte ? i_rdata[15:8] : i_rdata[7:0];
    w_sign = w_byte[7] & ~i_unsigned;
    o_data = i_byte ? {{(DATA_WIDTH-8){w_sign}}, w_byte} : i_rdata;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data port, stalling the
// pipeline until the access completes; non-memory instructions pass straight through.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_valid,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic                     ex_mem_write,
  input  logic                     ex_byte,
  input  logic                     ex_unsigned,
  input  logic [DATA_WIDTH-1:0]    ex_alu_result,
  input  logic [DATA_WIDTH-1:0]    ex_store_data,
  input  logic [REGADDR_WIDTH-1:0] ex_rd,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [DATA_WIDTH-2:0]    dmem_addr,
  output logic [1:0]               dmem_be,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     mem_stall,
  output logic                     mem_misalign,
  output logic                     mem_reg_write,
  output logic                     mem_mem_read,
  output logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic [DATA_WIDTH-1:0]    mem_alu_result,
  output logic [REGADDR_WIDTH-1:0] mem_rd
);

  memState_t             r_state;
  memState_t             w_nextState;
  logic                  r_req;
  logic                  r_we;
  logic [DATA_WIDTH-2:0] r_addr;
  logic [1:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_loadBuf;
  logic                  r_isRead;
  logic                  r_byte;
  logic                  r_hiByte;
  logic                  r_unsigned;

  logic                  w_memOp;
  logic                  w_isWrite;
  logic                  w_misalign;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_loadExt;

  // A load that also has mem_write set is treated purely as a load.
  assign w_memOp    = ex_valid & (ex_mem_read | ex_mem_write);
  assign w_isWrite  = ex_mem_write & ~ex_mem_read;
  assign w_misalign = w_memOp & ~ex_byte & ex_alu_result[0];
  assign w_start    = w_memOp & ~w_misalign;

  load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_loadExtend (
    .i_rdata    (dmem_rdata),
    .i_byte     (r_byte),
    .i_hiByte   (r_hiByte),
    .i_unsigned (r_unsigned),
    .o_data     (w_loadExt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_loadBuf  <= '0;
      r_isRead   <= 1'b0;
      r_byte     <= 1'b0;
      r_hiByte   <= 1'b0;
      r_unsigned <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_start) begin
        r_req      <= 1'b1;
        r_we       <= w_isWrite;
        r_addr     <= ex_alu_result[DATA_WIDTH-1:1];
        r_be       <= ex_byte ? (ex_alu_result[0] ? BE_HI : BE_LO) : BE_WORD;
        r_wdata    <= !w_isWrite ? '0 :
                      ex_byte ? {(DATA_WIDTH/8){ex_store_data[7:0]}} : ex_store_data;
        r_isRead   <= ex_mem_read;
        r_byte     <= ex_byte;
        r_hiByte   <= ex_alu_result[0];
        r_unsigned <= ex_unsigned;
      end else if (r_state == BUSY && dmem_ack) begin
        r_req     <= 1'b0;
        r_loadBuf <= r_isRead ? w_loadExt : '0;
      end
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

  // While stalled, mem_wb sees bubbles; reset forces every stage output low.
  always_comb begin
    w_nextState    = r_state;
    mem_stall      = 1'b0;
    mem_misalign   = 1'b0;
    mem_reg_write  = 1'b0;
    mem_mem_read   = 1'b0;
    mem_read_data  = '0;
    mem_alu_result = ex_alu_result;
    mem_rd         = ex_rd;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          mem_stall   = 1'b1;
          w_nextState = BUSY;
        end else if (w_misalign) begin
          mem_misalign = 1'b1;
        end else begin
          mem_reg_write = ex_valid & ex_reg_write;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ack) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        mem_reg_write = ex_reg_write;
        mem_mem_read  = r_isRead;
        mem_read_data = r_loadBuf;
        w_nextState   = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (reset) begin
      mem_stall      = 1'b0;
      mem_misalign   = 1'b0;
      mem_reg_write  = 1'b0;
      mem_mem_read   = 1'b0;
      mem_read_data  = '0;
      mem_alu_result = '0;
      mem_rd         = '0;
    end
  end

endmodule
